// File: rtl/apm_pkg.sv
// Shared constants, types and helpers for the advanced power manager.
package apm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_ADJUST  = 3'd3,
    ST_SETTLE  = 3'd4
  } dvfs_state_e;

  localparam int          MEASURE_CYCLES   = 96;
  localparam logic [7:0]  MEASURE_LAST     = 8'(MEASURE_CYCLES - 1);
  localparam logic [7:0]  THERMAL_LIMIT_C  = 8'd85;
  localparam logic [2:0]  DEFAULT_LEVEL    = 3'd3;
  localparam logic [2:0]  LEVEL_CAP_FULL   = 3'd7;
  localparam logic [2:0]  LEVEL_CAP_LOW    = 3'd3;
  localparam logic [7:0]  MODE_PERFORMANCE = 8'd1;
  localparam logic [7:0]  MODE_LOW_POWER   = 8'd2;

  typedef struct packed {
    logic [15:0] power;
    logic [15:0] tops;
    logic [15:0] eff;
    logic [15:0] dyn;
    logic [15:0] leak;
    logic [3:0]  grade;
  } apm_metrics_t;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [2:0] freq_cap(input logic [7:0] mode);
    return (mode == MODE_LOW_POWER) ? LEVEL_CAP_LOW : LEVEL_CAP_FULL;
  endfunction

endpackage

// File: rtl/apm_dvfs_ctrl.sv
// DVFS controller: measures for a fixed window, decides a single-level step,
// applies it and dwells before measuring again. Voltage tracks this level.
module apm_dvfs_ctrl
  import apm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  power_mode_i,
  input  logic [7:0]  temperature_i,
  input  logic [15:0] power_mw_i,
  input  logic [15:0] power_budget_i,
  input  logic [15:0] util_ma_i,
  input  logic [15:0] efficiency_i,
  input  logic [15:0] perf_target_i,
  input  logic [15:0] perf_margin_i,
  input  logic [7:0]  util_high_i,
  input  logic [7:0]  util_low_i,
  input  logic [7:0]  settle_cycles_i,
  output logic [2:0]  level_o,
  output dvfs_state_e state_o
);

  dvfs_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  level_q, level_d;
  logic        step_up_q, step_up_d;

  logic [2:0]  cap;
  logic [7:0]  high_thr;
  logic [7:0]  settle_last;
  logic [16:0] eff_ceiling;
  logic        too_hot, over_budget, want_down, want_up;

  assign cap         = freq_cap(power_mode_i);
  assign high_thr    = (power_mode_i == MODE_PERFORMANCE) ? {1'b0, util_high_i[7:1]} : util_high_i;
  assign settle_last = (settle_cycles_i == 8'd0) ? 8'd0 : settle_cycles_i - 8'd1;
  assign eff_ceiling = {1'b0, perf_target_i} + {1'b0, perf_margin_i};
  assign too_hot     = temperature_i >= THERMAL_LIMIT_C;
  assign over_budget = power_mw_i > power_budget_i;

  // Downscaling wins; a level above the current mode's cap is always stepped down.
  assign want_down = (too_hot || over_budget || (util_ma_i < {8'h00, util_low_i}) ||
                      ({1'b0, efficiency_i} > eff_ceiling) || (level_q > cap)) &&
                     (level_q != 3'd0);
  assign want_up   = (util_ma_i > {8'h00, high_thr}) && (efficiency_i < perf_target_i) &&
                     !too_hot && !over_budget && (level_q < cap);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    step_up_d = step_up_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_MEASURE;
        cnt_d   = 8'd0;
      end
      ST_MEASURE: begin
        if (cnt_q == MEASURE_LAST) begin
          state_d = ST_DECIDE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DECIDE: begin
        if (want_down) begin
          state_d   = ST_ADJUST;
          step_up_d = 1'b0;
        end else if (want_up) begin
          state_d   = ST_ADJUST;
          step_up_d = 1'b1;
        end else begin
          state_d = ST_MEASURE;
          cnt_d   = 8'd0;
        end
      end
      ST_ADJUST: begin
        level_d = step_up_q ? level_q + 3'd1 : level_q - 3'd1;
        state_d = ST_SETTLE;
        cnt_d   = 8'd0;
      end
      ST_SETTLE: begin
        if (cnt_q >= settle_last) begin
          state_d = ST_MEASURE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      level_q   <= DEFAULT_LEVEL;
      step_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      step_up_q <= step_up_d;
    end
  end

  assign level_o = level_q;
  assign state_o = state_q;

endmodule

// File: rtl/advanced_power_manager.sv
// Power manager top: per-PE gating, quarter-domain enables, power/efficiency
// estimation and a utilisation average feeding the DVFS controller.
module advanced_power_manager
  import apm_pkg::*;
#(
  parameter int NUM_PES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         power_mode,
  input  logic [15:0]        utilization_target,
  input  logic [15:0]        performance_target,
  input  logic [NUM_PES-1:0] pe_active,
  input  logic [NUM_PES-1:0] pe_request,
  input  logic [15:0]        current_ops_count,
  input  logic [1:0]         precision_mode,
  input  logic [7:0]         temperature,
  input  logic [15:0]        power_budget,
  input  logic [7:0]         util_high_thresh_pct_cfg,
  input  logic [7:0]         util_low_thresh_pct_cfg,
  input  logic [15:0]        perf_hyst_margin_milli_cfg,
  input  logic [7:0]         dvfs_min_settle_cycles_cfg,
  output logic [3:0]         domain_power_enable,
  output logic [3:0]         domain_clock_enable,
  output logic [NUM_PES-1:0] pe_power_gate,
  output logic [NUM_PES-1:0] pe_clock_gate,
  output logic [2:0]         voltage_setting,
  output logic [2:0]         frequency_setting,
  output logic [15:0]        current_power_mw,
  output logic [15:0]        current_tops,
  output logic [15:0]        efficiency_tops_w,
  output logic [15:0]        dynamic_power_mw,
  output logic [15:0]        leakage_power_mw,
  output logic [15:0]        utilization_ma_out,
  output logic [3:0]         power_efficiency_grade
);

  localparam int DOM_W = NUM_PES / 4;

  apm_metrics_t       metrics_q, metrics_d;
  logic [15:0]        util_ma_q, util_ma_d;
  logic [NUM_PES-1:0] pgate_q, cgate_q;
  logic [3:0]         dom_pwr_q, dom_pwr_d, dom_clk_q, dom_clk_d;
  logic [17:0]        info_q;
  logic [2:0]         level;
  dvfs_state_e        dvfs_state;

  logic [NUM_PES-1:0] on_vec;
  logic [31:0]        act_cnt, on_cnt, util_pct, lvl, dyn_raw, leak_raw, pwr_raw, tops_raw, eff_raw;
  logic signed [31:0] ma_cur, ma_step;

  always_comb begin
    metrics_d = '0;
    on_vec    = pe_active | pe_request;
    act_cnt   = 32'd0;
    on_cnt    = 32'd0;
    for (int i = 0; i < NUM_PES; i++) begin
      act_cnt = act_cnt + 32'(pe_active[i]);
      on_cnt  = on_cnt + 32'(on_vec[i]);
    end
    util_pct  = act_cnt * 32'd100 / 32'(NUM_PES);
    // Signed division so a falling average truncates toward zero, not toward -inf.
    ma_cur    = signed'({16'h0000, util_ma_q});
    ma_step   = (signed'(util_pct) - ma_cur) / 32'sd8;
    util_ma_d = 16'(ma_cur + ma_step);

    lvl      = 32'(level) + 32'd1;
    dyn_raw  = act_cnt * lvl * lvl * 32'd2;
    leak_raw = on_cnt * lvl;
    pwr_raw  = dyn_raw + leak_raw;
    tops_raw = (32'(current_ops_count) * lvl) >> 4;

    metrics_d.power = sat16(pwr_raw);
    metrics_d.tops  = sat16(tops_raw);
    metrics_d.dyn   = sat16(dyn_raw);
    metrics_d.leak  = sat16(leak_raw);
    eff_raw         = (metrics_d.power == 16'd0) ? 32'd0 :
                      (32'(metrics_d.tops) * 32'd1000) / 32'(metrics_d.power);
    metrics_d.eff   = sat16(eff_raw);
    metrics_d.grade = (metrics_d.eff >= 16'd1500) ? 4'd15 : 4'(metrics_d.eff / 16'd100);

    for (int d = 0; d < 4; d++) begin
      dom_pwr_d[d] = |on_vec[d*DOM_W +: DOM_W];
      dom_clk_d[d] = |pe_active[d*DOM_W +: DOM_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      metrics_q <= '0;
      util_ma_q <= 16'd0;
      pgate_q   <= '1;
      cgate_q   <= '1;
      dom_pwr_q <= 4'd0;
      dom_clk_q <= 4'd0;
      info_q    <= 18'd0;
    end else begin
      metrics_q <= metrics_d;
      util_ma_q <= util_ma_d;
      pgate_q   <= ~on_vec;
      cgate_q   <= ~pe_active;
      dom_pwr_q <= dom_pwr_d;
      dom_clk_q <= dom_clk_d;
      info_q    <= {utilization_target, precision_mode};
    end
  end

  apm_dvfs_ctrl u_dvfs (
    .clk             (clk),
    .rst_n           (reset),
    .power_mode_i    (power_mode),
    .temperature_i   (temperature),
    .power_mw_i      (metrics_q.power),
    .power_budget_i  (power_budget),
    .util_ma_i       (util_ma_q),
    .efficiency_i    (metrics_q.eff),
    .perf_target_i   (performance_target),
    .perf_margin_i   (perf_hyst_margin_milli_cfg),
    .util_high_i     (util_high_thresh_pct_cfg),
    .util_low_i      (util_low_thresh_pct_cfg),
    .settle_cycles_i (dvfs_min_settle_cycles_cfg),
    .level_o         (level),
    .state_o         (dvfs_state)
  );

  assign domain_power_enable    = dom_pwr_q;
  assign domain_clock_enable    = dom_clk_q;
  assign pe_power_gate          = pgate_q;
  assign pe_clock_gate          = cgate_q;
  assign voltage_setting        = level;
  assign frequency_setting      = level;
  assign current_power_mw       = metrics_q.power;
  assign current_tops           = metrics_q.tops;
  assign efficiency_tops_w      = metrics_q.eff;
  assign dynamic_power_mw       = metrics_q.dyn;
  assign leakage_power_mw       = metrics_q.leak;
  assign utilization_ma_out     = util_ma_q;
  assign power_efficiency_grade = metrics_q.grade;

endmodule

// File: tb/tb_advanced_power_manager.sv
// Bench for advanced_power_manager: datapath scoreboard at the default level,
// then DVFS trajectory scenarios with expected levels queued up front.
module tb_advanced_power_manager;

  localparam int N  = 16;
  localparam int LV = 4;  // default level 3, plus one
  localparam int EW = 140;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    power_mode;
  logic [15:0]   utilization_target, performance_target;
  logic [N-1:0]  pe_active, pe_request;
  logic [15:0]   current_ops_count;
  logic [1:0]    precision_mode;
  logic [7:0]    temperature;
  logic [15:0]   power_budget;
  logic [7:0]    util_high_thresh_pct_cfg, util_low_thresh_pct_cfg;
  logic [15:0]   perf_hyst_margin_milli_cfg;
  logic [7:0]    dvfs_min_settle_cycles_cfg;
  logic [3:0]    domain_power_enable, domain_clock_enable;
  logic [N-1:0]  pe_power_gate, pe_clock_gate;
  logic [2:0]    voltage_setting, frequency_setting;
  logic [15:0]   current_power_mw, current_tops, efficiency_tops_w;
  logic [15:0]   dynamic_power_mw, leakage_power_mw, utilization_ma_out;
  logic [3:0]    power_efficiency_grade;

  advanced_power_manager #(.NUM_PES(N)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .power_mode                 (power_mode),
    .utilization_target         (utilization_target),
    .performance_target         (performance_target),
    .pe_active                  (pe_active),
    .pe_request                 (pe_request),
    .current_ops_count          (current_ops_count),
    .precision_mode             (precision_mode),
    .temperature                (temperature),
    .power_budget               (power_budget),
    .util_high_thresh_pct_cfg   (util_high_thresh_pct_cfg),
    .util_low_thresh_pct_cfg    (util_low_thresh_pct_cfg),
    .perf_hyst_margin_milli_cfg (perf_hyst_margin_milli_cfg),
    .dvfs_min_settle_cycles_cfg (dvfs_min_settle_cycles_cfg),
    .domain_power_enable        (domain_power_enable),
    .domain_clock_enable        (domain_clock_enable),
    .pe_power_gate              (pe_power_gate),
    .pe_clock_gate              (pe_clock_gate),
    .voltage_setting            (voltage_setting),
    .frequency_setting          (frequency_setting),
    .current_power_mw           (current_power_mw),
    .current_tops               (current_tops),
    .efficiency_tops_w          (efficiency_tops_w),
    .dynamic_power_mw           (dynamic_power_mw),
    .leakage_power_mw           (leakage_power_mw),
    .utilization_ma_out         (utilization_ma_out),
    .power_efficiency_grade     (power_efficiency_grade)
  );

  // Clock and cycle counter (edges since reset release)
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard state
  int              n_checks = 0;
  int              n_errors = 0;
  int              m_ma     = 0;
  logic [EW-1:0]   exp_q[$];
  logic [2:0]      lvl_exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic setup(input logic [7:0] mode, input logic [7:0] hi, input logic [7:0] lo,
                       input logic [7:0] settle, input logic [15:0] target, input logic [15:0] margin,
                       input logic [15:0] budget, input logic [7:0] temp,
                       input logic [15:0] act, input logic [15:0] ops);
    power_mode                 = mode;
    util_high_thresh_pct_cfg   = hi;
    util_low_thresh_pct_cfg    = lo;
    dvfs_min_settle_cycles_cfg = settle;
    performance_target         = target;
    perf_hyst_margin_milli_cfg = margin;
    power_budget               = budget;
    temperature                = temp;
    pe_active                  = act;
    pe_request                 = 16'h0000;
    current_ops_count          = ops;
    utilization_target         = 16'd50;
    precision_mode             = 2'd1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_frequency", 32'(frequency_setting), 32'd3);
    check("rst_voltage", 32'(voltage_setting), 32'd3);
    check("rst_pe_power_gate", 32'(pe_power_gate), 32'h0000FFFF);
    check("rst_pe_clock_gate", 32'(pe_clock_gate), 32'h0000FFFF);
    check("rst_domain_power", 32'(domain_power_enable), 32'd0);
    check("rst_domain_clock", 32'(domain_clock_enable), 32'd0);
    check("rst_power", 32'(current_power_mw), 32'd0);
    check("rst_tops", 32'(current_tops), 32'd0);
    check("rst_efficiency", 32'(efficiency_tops_w), 32'd0);
    check("rst_grade", 32'(power_efficiency_grade), 32'd0);
    check("rst_util_ma", 32'(utilization_ma_out), 32'd0);
    m_ma  = 0;
    reset = 1'b1;
  endtask

  // Drive one datapath vector and queue what the registered outputs must show.
  task automatic drive_dp(input logic [15:0] act, input logic [15:0] req, input logic [15:0] ops);
    int ac, on, pct, dyn, leak, pwr, tops, eff, grd;
    logic [15:0] onv;
    logic [3:0]  dp, dc;
    pe_active         = act;
    pe_request        = req;
    current_ops_count = ops;
    onv  = act | req;
    ac   = $countones(act);
    on   = $countones(onv);
    pct  = ac * 100 / N;
    m_ma = m_ma + (pct - m_ma) / 8;
    dyn  = ac * LV * LV * 2;
    leak = on * LV;
    pwr  = dyn + leak;
    tops = (int'(ops) * LV) >> 4;
    eff  = (pwr == 0) ? 0 : tops * 1000 / pwr;
    if (eff > 65535) eff = 65535;
    grd  = eff / 100;
    if (grd > 15) grd = 15;
    for (int d = 0; d < 4; d++) begin
      dp[d] = |onv[d*4 +: 4];
      dc[d] = |act[d*4 +: 4];
    end
    exp_q.push_back({~onv, ~act, dp, dc, 16'(pwr), 16'(tops), 16'(eff),
                     16'(dyn), 16'(leak), 16'(m_ma), 4'(grd)});
  endtask

  task automatic compare_dp();
    logic [15:0] e_pg, e_cg, e_pw, e_tp, e_ef, e_dy, e_lk, e_ma;
    logic [3:0]  e_dp, e_dc, e_gr;
    {e_pg, e_cg, e_dp, e_dc, e_pw, e_tp, e_ef, e_dy, e_lk, e_ma, e_gr} = exp_q.pop_front();
    check("pe_power_gate", 32'(pe_power_gate), 32'(e_pg));
    check("pe_clock_gate", 32'(pe_clock_gate), 32'(e_cg));
    check("domain_power", 32'(domain_power_enable), 32'(e_dp));
    check("domain_clock", 32'(domain_clock_enable), 32'(e_dc));
    check("power_mw", 32'(current_power_mw), 32'(e_pw));
    check("tops", 32'(current_tops), 32'(e_tp));
    check("efficiency", 32'(efficiency_tops_w), 32'(e_ef));
    check("dynamic_mw", 32'(dynamic_power_mw), 32'(e_dy));
    check("leakage_mw", 32'(leakage_power_mw), 32'(e_lk));
    check("util_ma", 32'(utilization_ma_out), 32'(e_ma));
    check("grade", 32'(power_efficiency_grade), 32'(e_gr));
  endtask

  task automatic check_level_at(input int c, input string tag);
    logic [2:0] e;
    wait_cycle(c);
    e = lvl_exp_q.pop_front();
    check({tag, "_freq"}, 32'(frequency_setting), 32'(e));
    check({tag, "_volt"}, 32'(voltage_setting), 32'(e));
  endtask

  initial begin
    reset = 1'b0;
    setup(8'd0, 8'd30, 8'd20, 8'd1, 16'hFFFF, 16'd0, 16'hFFFF, 8'd40, 16'h0000, 16'h0000);

    // Datapath at the default level: stays inside the first measurement window
    do_reset();
    for (int it = 0; it < 64; it++) begin
      @(negedge clk);
      if (exp_q.size() > 0) compare_dp();
      case (it)
        0:       drive_dp(16'h0000, 16'h0000, 16'h0000);
        1:       drive_dp(16'hFFFF, 16'h0000, 16'hFFFF);
        2:       drive_dp(16'h0000, 16'hFFFF, 16'd100);
        3:       drive_dp(16'h000F, 16'hF000, 16'd1234);
        4:       drive_dp(16'h0001, 16'h0000, 16'hFFFF);
        5:       drive_dp(16'h0000, 16'h0000, 16'h0000);
        default: drive_dp(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                          16'($urandom_range(0, 65535)));
      endcase
    end
    @(negedge clk);
    compare_dp();

    // Upscale once to 4, hold through settle, then over-budget pulls back to 3
    setup(8'd0, 8'd30, 8'd20, 8'd255, 16'd2000, 16'd100, 16'd800, 8'd40, 16'h0003, 16'h0000);
    lvl_exp_q = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd3};
    do_reset();
    check_level_at(20, "s1_c20");
    wait_cycle(25);
    pe_active = 16'hFFFF;
    check_level_at(150, "s1_c150");
    check_level_at(260, "s1_c260");
    check_level_at(400, "s1_c400");
    check_level_at(500, "s1_c500");

    // Low utilisation steps down once per decision to the floor
    setup(8'd0, 8'd30, 8'd20, 8'd1, 16'hFFFF, 16'd0, 16'hFFFF, 8'd40, 16'h0003, 16'h0000);
    lvl_exp_q = '{3'd2, 3'd1, 3'd0, 3'd0};
    do_reset();
    check_level_at(120, "s2_c120");
    check_level_at(220, "s2_c220");
    check_level_at(320, "s2_c320");
    check_level_at(450, "s2_c450");

    // Hot die with full activity: never upscales
    setup(8'd0, 8'd30, 8'd20, 8'd1, 16'hFFFF, 16'd0, 16'hFFFF, 8'd90, 16'hFFFF, 16'h0000);
    lvl_exp_q = '{3'd2, 3'd1, 3'd0, 3'd0};
    do_reset();
    check_level_at(120, "s3_c120");
    check_level_at(220, "s3_c220");
    check_level_at(320, "s3_c320");
    check_level_at(450, "s3_c450");

    // Low-power mode caps at 3
    setup(8'd2, 8'd30, 8'd20, 8'd1, 16'hFFFF, 16'd0, 16'hFFFF, 8'd40, 16'hFFFF, 16'h0000);
    lvl_exp_q = '{3'd3, 3'd3, 3'd3};
    do_reset();
    check_level_at(120, "s4_c120");
    check_level_at(220, "s4_c220");
    check_level_at(320, "s4_c320");

    // Efficiency above target plus margin steps down
    setup(8'd0, 8'd30, 8'd20, 8'd1, 16'd1000, 16'd100, 16'hFFFF, 8'd40, 16'hFFFF, 16'hFFFF);
    lvl_exp_q = '{3'd2};
    do_reset();
    check_level_at(120, "s5_c120");

    // Performance mode halves the high threshold (180 -> 90); switching to
    // low-power forces single steps down to the cap; reset mid-run restarts.
    setup(8'd1, 8'd180, 8'd0, 8'd1, 16'hFFFF, 16'd0, 16'hFFFF, 8'd40, 16'hFFFF, 16'h0000);
    lvl_exp_q = '{3'd4, 3'd5, 3'd4, 3'd3, 3'd3, 3'd4};
    do_reset();
    check_level_at(120, "s6_c120");
    check_level_at(220, "s6_c220");
    power_mode = 8'd2;
    check_level_at(320, "s6_c320");
    check_level_at(420, "s6_c420");
    power_mode = 8'd1;
    wait_cycle(430);
    do_reset();
    check_level_at(60, "s6_restart_c60");
    check_level_at(120, "s6_restart_c120");

    // Balanced mode with the same 180 threshold must not upscale
    setup(8'd0, 8'd180, 8'd0, 8'd1, 16'hFFFF, 16'd0, 16'hFFFF, 8'd40, 16'hFFFF, 16'h0000);
    lvl_exp_q = '{3'd3};
    do_reset();
    check_level_at(120, "s7_c120");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
